// File: rtl/dbg_tx_printer_if.sv
// Print-request and UART byte-stream signals of the debug transmit printer.
// master: command processor + UART side; slave: the printer itself.
interface dbg_tx_printer_if;
  logic        req_tx;
  logic        type_tx;
  logic [31:0] din_tx;
  logic        ack_tx;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        tx_rdy;
  logic        busy;

  modport master (
    output req_tx, type_tx, din_tx, tx_rdy,
    input  ack_tx, tx_data, tx_vld, busy
  );

  modport slave (
    input  req_tx, type_tx, din_tx, tx_rdy,
    output ack_tx, tx_data, tx_vld, busy
  );
endinterface

// File: rtl/dbg_tx_printer.sv
// Serialises a debug print request (raw byte or 8 hex digits) to a UART byte sink.
// Optional DBG_TX_PRINTER_LOWERCASE_EN prints hex digits a-f instead of A-F.
module dbg_tx_printer (
  input  logic              clk,
  input  logic              rstn,
  dbg_tx_printer_if.slave   bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    ACK     = 2'd2,
    WAITLOW = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] sh, sh_nxt;
  logic        ty, ty_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        xfer;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] c;
    if (n <= 4'd9) begin
      c = 8'h30 + {4'h0, n};
    end else begin
`ifdef DBG_TX_PRINTER_LOWERCASE_EN
      c = 8'h61 + {4'h0, n - 4'd10};
`else
      c = 8'h41 + {4'h0, n - 4'd10};
`endif
    end
    return c;
  endfunction

  // Handshake: a character moves on every rising edge where tx_vld && tx_rdy;
  // tx_vld never drops and tx_data never changes until that happens.
  assign xfer = (state == SEND) && bus.tx_rdy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      sh    <= 32'h0;
      ty    <= 1'b0;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      sh    <= sh_nxt;
      ty    <= ty_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    ty_nxt    = ty;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.req_tx) begin
          sh_nxt    = bus.din_tx;
          ty_nxt    = bus.type_tx;
          cnt_nxt   = bus.type_tx ? 3'd7 : 3'd0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (cnt == 3'd0) begin
            state_nxt = ACK;
          end else begin
            cnt_nxt = cnt - 3'd1;
            sh_nxt  = {sh[27:0], 4'h0};
          end
        end
      end
      ACK: begin
        state_nxt = WAITLOW;
      end
      WAITLOW: begin
        // A request left high after its ack must not start a second print.
        if (!bus.req_tx) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode registered state only; nothing here depends on tx_rdy or req_tx.
  assign bus.tx_vld  = (state == SEND);
  assign bus.tx_data = (state == SEND) ? (ty ? hex_char(sh[31:28]) : sh[7:0]) : 8'h00;
  assign bus.ack_tx  = (state == ACK);
  assign bus.busy    = (state != IDLE);
  assign dbg_state   = state;

endmodule

// File: tb/tb_dbg_tx_printer.sv
// Bench for dbg_tx_printer: directed steps plus random prints against a string-based model.
module tb_dbg_tx_printer;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] dbg_state;

  dbg_tx_printer_if bus ();

  dbg_tx_printer dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected character stream: the raw low byte, or the value printed as hex text.
  function automatic void model(input logic t, input logic [31:0] d);
    string s;
    exp_q.delete();
    if (!t) begin
      exp_q.push_back(d[7:0]);
    end else begin
      s = $sformatf("%h", d);
`ifdef DBG_TX_PRINTER_LOWERCASE_EN
      s = s.tolower();
`else
      s = s.toupper();
`endif
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    end
  endfunction

  // rdy_mode: 0 always ready, 1 toggling starting ready, 2 random.
  // chg_cycle: cycle to scramble din/type; drop_cycle: cycle to drop req (0 = never).
  task automatic run_xfer(input logic t, input logic [31:0] d, input int rdy_mode,
                          input int hold, input int chg_cycle, input int drop_cycle);
    int   c;
    int   a;
    int   stalls;
    int   nchar;
    logic rdy;
    model(t, d);
    nchar  = exp_q.size();
    stalls = 0;
    a      = 0;
    bus.req_tx  = 1'b1;
    bus.type_tx = t;
    bus.din_tx  = d;
    bus.tx_rdy  = 1'b0;
    @(posedge clk); #1;
    c = 1;
    while (c < 200) begin
      if (bus.ack_tx) begin
        a = c;
        break;
      end
      if (c == chg_cycle) begin
        bus.din_tx  = ~d;
        bus.type_tx = ~t;
      end
      if (c == drop_cycle) bus.req_tx = 1'b0;
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (c % 2 == 1);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.tx_rdy = rdy;
      if (exp_q.size() > 0) begin
        check("tx_vld", bus.tx_vld, 1);
        check("busy_send", bus.busy, 1);
        check("tx_data", bus.tx_data, exp_q[0]);
        if (rdy) void'(exp_q.pop_front());
        else stalls++;
      end else begin
        check("vld_no_pending", bus.tx_vld, 0);
      end
      @(posedge clk); #1;
      c++;
    end
    check("ack_seen", a != 0, 1);
    check("ack_cycle", a, nchar + stalls + 1);
    check("chars_left", exp_q.size(), 0);
    check("vld_in_ack", bus.tx_vld, 0);
    bus.tx_rdy = 1'($urandom_range(0, 1));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("ack_once", bus.ack_tx, 0);
      check("busy_waitlow", bus.busy, 1);
      check("vld_waitlow", bus.tx_vld, 0);
    end
    bus.req_tx = 1'b0;
    @(posedge clk); #1;
    check("busy_idle", bus.busy, 0);
    check("ack_idle", bus.ack_tx, 0);
  endtask

  initial begin
    rstn        = 1'b0;
    bus.req_tx  = 1'b0;
    bus.type_tx = 1'b0;
    bus.din_tx  = 32'h0;
    bus.tx_rdy  = 1'b0;
    #12;
    check("rst_vld", bus.tx_vld, 0);
    check("rst_ack", bus.ack_tx, 0);
    check("rst_data", bus.tx_data, 8'h00);
    check("rst_busy", bus.busy, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    run_xfer(1'b0, 32'h1234_5641, 0, 1, 0, 0);
    run_xfer(1'b1, 32'hDEAD_0123, 0, 1, 0, 0);
    run_xfer(1'b1, 32'h0000_00FF, 1, 1, 0, 0);
    run_xfer(1'b0, 32'h0000_00A5, 0, 5, 0, 0);
    run_xfer(1'b1, 32'h0000_0000, 0, 1, 2, 0);
    run_xfer(1'b1, 32'h89AB_CDEF, 2, 1, 0, 3);

    // Reset while the 4th hex character is on the bus.
    bus.req_tx  = 1'b1;
    bus.type_tx = 1'b1;
    bus.din_tx  = 32'h5555_AAAA;
    bus.tx_rdy  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    check("pre_rst_data", bus.tx_data, 8'h35);
    rstn = 1'b0;
    #1;
    check("mid_rst_vld", bus.tx_vld, 0);
    check("mid_rst_ack", bus.ack_tx, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_data", bus.tx_data, 8'h00);
    bus.req_tx = 1'b0;
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ack", bus.ack_tx, 0);
    check("post_rst_busy", bus.busy, 0);
    run_xfer(1'b0, 32'h0000_003C, 0, 1, 0, 0);

    for (int k = 0; k < 24; k++) begin
      run_xfer(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 2),
               $urandom_range(1, 3), 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
